edge_raster: RTL and testbench
==============================

// Module: edge_raster
// PURPOSE
//  Upstream stage of the fill block. Rasterises the edges of a 2-vertex segment or a 3-vertex triangle
//  into a 64x64 one-bit edge bitmap (line_buffer), anchored at the primitive's bounding-box minimum.
//  Uses Bresenham stepping at one pixel per clock. The fill block consumes line_buffer row by row.
//  Row r = y - ymin, column c = x - xmin, bit index r*64 + c.
// PARAMETERS
//  GRID_DIM    64  bitmap side length; line_buffer is GRID_DIM*GRID_DIM bits; only 64 is supported
//  COORD_BITS   8  bits per vertex coordinate
// PORTS
//  clk           in   1     system clock, rising edge
//  n_rst         in   1     reset, asynchronous, active-low
//  raster_en     in   1     start pulse; sampled only in IDLE
//  coordinates   in   48    {y2,x2,y1,x1,y0,x0}, 8 bits each; x0=[7:0], y0=[15:8], x1=[23:16], y1=[31:24], x2=[39:32], y2=[47:40]
//  vertice_num   in   1     0 = segment V0->V1; 1 = triangle V0->V1, V1->V2, V2->V0
//  line_buffer   out  4096  edge bitmap; bit r*64+c set = edge pixel at (xmin+c, ymin+r)
//  raster_busy   out  1     high in every state except IDLE
//  raster_done   out  1     single-cycle pulse; line_buffer is complete and stable
// BEHAVIOUR
//  Clock and reset: one clock (clk). Reset is asynchronous and active-low (n_rst).
//  Reset values: line_buffer=0, raster_done=0, raster_busy=0, state=IDLE, all internal registers 0.
//  Reset mid-operation aborts immediately to these values; no partial result is preserved.
//  FSM: IDLE -> MINMAX -> SETUP -> STEP -> (SETUP | DONE) -> IDLE.
//  IDLE
//    - raster_en=1 -> MINMAX.
//  MINMAX (1 cycle)
//    - Latch coordinates and vertice_num; upstream may change them after this cycle.
//    - Compute xmin/ymin over the 2 or 3 vertices.
//    - Clear line_buffer to 0. Set seg=0.
//  SETUP (1 cycle): load the endpoints of segment seg.
//    - seg0 = V0->V1, seg1 = V1->V2, seg2 = V2->V0.
//    - dx=|x1-x0|, dy=|y1-y0| (9-bit unsigned); sx/sy = +1 or -1.
//    - err = dx - dy, 11-bit signed. Current point (cx,cy) = start vertex.
//  STEP (one pixel per cycle)
//    - Plot: if (cx-xmin)<64 and (cy-ymin)<64, set bit (cy-ymin)*64+(cx-xmin).
//    - Out-of-range pixels are dropped. No wrap into the next row. No modulo indexing.
//    - If (cx,cy) == end vertex, the segment is finished. Next state:
//        seg < last segment -> seg+1, SETUP
//        otherwise -> DONE
//      Last segment is 0 for a segment, 2 for a triangle.
//    - Otherwise: e2 = 2*err (11-bit signed).
//        if e2 > -dy: err -= dy; cx += sx
//        if e2 <  dx: err += dx; cy += sy
//      Both updates use the pre-step err.
//    - A segment takes max(dx,dy)+1 STEP cycles. A degenerate segment (start == end) takes 1 cycle and plots 1 pixel.
//  DONE (1 cycle)
//    - raster_done=1, then IDLE.
//    - line_buffer holds its value until the next MINMAX.
//  Latency, segment: raster_en sampled at edge 0; MINMAX cycle 1, SETUP cycle 2, STEP cycles 3..2+L, DONE at 3+L, where L=max(dx,dy)+1.
//  Latency, triangle: sum over segments of (1 + L_seg) + 2 cycles.
//  raster_en while busy: ignored; no restart, no queueing.
//  Shared vertices: pixels plotted by two segments are simply OR-set.
//  Arithmetic: all coordinate math is unsigned 8-bit. Offsets are always >= 0 because xmin/ymin are minima.
// TESTING
//  1. Horizontal, V0=(10,20), V1=(15,20), vertice_num=0 -> bits 0..5 set, all others 0;
//     raster_done pulses 9 cycles after raster_en is sampled.
//  2. Diagonal, (0,0)->(3,3) -> exactly bits 0, 65, 130, 195 set; STEP lasts 4 cycles.
//  3. Triangle (5,5),(9,5),(5,9), vertice_num=1 -> popcount 12:
//     row0 cols0-4; col0 rows0-4; bits r*64+(4-r) for r=0..4.
//  4. Clipping, (0,0)->(100,0) -> bits 0..63 set; bit 64 and above clear; STEP lasts 101 cycles.
//  5. Point (7,7)->(7,7) -> only bit 0 set; done at cycle 4.
//     raster_en reasserted during STEP -> no effect on the result.
//  6. n_rst low during STEP of case 3 -> line_buffer=0, busy=0, done=0 asynchronously;
//     a new run after release gives the correct bitmap.

Source files
------------

// File: rtl/edge_raster.sv
// Bresenham edge rasteriser: plots the edges of a segment or triangle into a 64x64 bitmap
// anchored at the primitive's bounding-box minimum, one pixel per clock.
//   state  | meaning
//   IDLE   | waiting for raster_en
//   MINMAX | latch vertices, compute bbox minimum, clear bitmap
//   SETUP  | load deltas/direction/error for segment r_seg
//   STEP   | plot current pixel, advance one Bresenham step
//   DONE   | one-cycle completion pulse
module edge_raster #(
  parameter int GRID_DIM   = 64,
  parameter int COORD_BITS = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         raster_en,
  input  logic [6*COORD_BITS-1:0]      coordinates,
  input  logic                         vertice_num,
  output logic [GRID_DIM*GRID_DIM-1:0] line_buffer,
  output logic                         raster_busy,
  output logic                         raster_done
);

  localparam int CB = COORD_BITS;

  typedef enum logic [2:0] {IDLE, MINMAX, SETUP, STEP, DONE} state_t;

  state_t                r_state, w_next;
  logic [6*CB-1:0]       r_coords;
  logic                  r_tri;
  logic [CB-1:0]         r_xmin, r_ymin, r_cx, r_cy, r_ex, r_ey;
  logic [1:0]            r_seg;
  logic [CB:0]           r_dx, r_dy;
  logic                  r_negx, r_negy;
  logic signed [CB+2:0]  r_err;

  logic [CB-1:0]         w_ix [3];
  logic [CB-1:0]         w_iy [3];
  logic [CB-1:0]         w_vx [3];
  logic [CB-1:0]         w_vy [3];
  logic [CB-1:0]         w_xmin, w_ymin, w_sx, w_sy, w_ex, w_ey, w_ox, w_oy;
  logic [CB:0]           w_dx, w_dy;
  logic signed [CB+2:0]  w_e2, w_sdx, w_sdy;
  logic                  w_at_end, w_last, w_step_x, w_step_y;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ix[i] = coordinates[2*CB*i +: CB];
      w_iy[i] = coordinates[2*CB*i+CB +: CB];
      w_vx[i] = r_coords[2*CB*i +: CB];
      w_vy[i] = r_coords[2*CB*i+CB +: CB];
    end
    w_xmin = (w_ix[1] < w_ix[0]) ? w_ix[1] : w_ix[0];
    w_ymin = (w_iy[1] < w_iy[0]) ? w_iy[1] : w_iy[0];
    if (vertice_num && w_ix[2] < w_xmin) w_xmin = w_ix[2];
    if (vertice_num && w_iy[2] < w_ymin) w_ymin = w_iy[2];
  end

  always_comb begin
    w_sx = w_vx[0]; w_sy = w_vy[0]; w_ex = w_vx[1]; w_ey = w_vy[1];
    case (r_seg)
      2'd1: begin w_sx = w_vx[1]; w_sy = w_vy[1]; w_ex = w_vx[2]; w_ey = w_vy[2]; end
      2'd2: begin w_sx = w_vx[2]; w_sy = w_vy[2]; w_ex = w_vx[0]; w_ey = w_vy[0]; end
      default: ;
    endcase
    w_dx = (w_ex >= w_sx) ? {1'b0, w_ex - w_sx} : {1'b0, w_sx - w_ex};
    w_dy = (w_ey >= w_sy) ? {1'b0, w_ey - w_sy} : {1'b0, w_sy - w_ey};
  end

  // Offsets never go negative because the minima cover every vertex on the segment.
  assign w_ox     = r_cx - r_xmin;
  assign w_oy     = r_cy - r_ymin;
  assign w_at_end = (r_cx == r_ex) && (r_cy == r_ey);
  assign w_last   = r_tri ? (r_seg == 2'd2) : (r_seg == 2'd0);
  assign w_sdx    = $signed({2'b00, r_dx});
  assign w_sdy    = $signed({2'b00, r_dy});
  assign w_e2     = r_err <<< 1;
  assign w_step_x = w_e2 > -w_sdy;
  assign w_step_y = w_e2 < w_sdx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (raster_en) w_next = MINMAX;
      MINMAX:  w_next = SETUP;
      SETUP:   w_next = STEP;
      STEP:    if (w_at_end) w_next = w_last ? DONE : SETUP;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign raster_busy = (r_state != IDLE);
  assign raster_done = (r_state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_buffer <= '0;
      r_coords <= '0; r_tri <= 1'b0; r_seg <= '0;
      r_xmin <= '0; r_ymin <= '0; r_cx <= '0; r_cy <= '0; r_ex <= '0; r_ey <= '0;
      r_dx <= '0; r_dy <= '0; r_negx <= 1'b0; r_negy <= 1'b0; r_err <= '0;
    end else begin
      case (r_state)
        MINMAX: begin
          r_coords    <= coordinates;
          r_tri       <= vertice_num;
          r_xmin      <= w_xmin;
          r_ymin      <= w_ymin;
          line_buffer <= '0;
          r_seg       <= '0;
        end
        SETUP: begin
          r_cx   <= w_sx;
          r_cy   <= w_sy;
          r_ex   <= w_ex;
          r_ey   <= w_ey;
          r_dx   <= w_dx;
          r_dy   <= w_dy;
          r_negx <= w_ex < w_sx;
          r_negy <= w_ey < w_sy;
          r_err  <= $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
        end
        STEP: begin
          // Pixels outside the 64x64 window are dropped rather than wrapped.
          if (w_ox < CB'(GRID_DIM) && w_oy < CB'(GRID_DIM))
            line_buffer[{w_oy[5:0], w_ox[5:0]}] <= 1'b1;
          if (w_at_end) begin
            if (!w_last) r_seg <= r_seg + 2'd1;
          end else begin
            r_err <= r_err - (w_step_x ? w_sdy : '0) + (w_step_y ? w_sdx : '0);
            if (w_step_x) r_cx <= r_negx ? r_cx - 1'b1 : r_cx + 1'b1;
            if (w_step_y) r_cy <= r_negy ? r_cy - 1'b1 : r_cy + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_raster.sv
// Self-checking bench for edge_raster: table of primitives with hand-derived bitmaps and
// latencies, checked through a scoreboard queue, plus restart-ignore and mid-run reset sequences.
module tb_edge_raster;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          raster_en = 1'b0;
  logic [47:0]   coordinates = '0;
  logic          vertice_num = 1'b0;
  logic [4095:0] line_buffer;
  logic          raster_busy, raster_done;

  always #5 clk = ~clk;

  edge_raster dut (
    .clk(clk), .n_rst(n_rst), .raster_en(raster_en), .coordinates(coordinates),
    .vertice_num(vertice_num), .line_buffer(line_buffer),
    .raster_busy(raster_busy), .raster_done(raster_done)
  );

  typedef struct {
    string         name;
    logic [47:0]   coords;
    logic          vnum;
    int            lat;
    int            pop;
    logic [4095:0] bm;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  function automatic logic [47:0] pk(int x0, int y0, int x1, int y1, int x2, int y2);
    logic [7:0] b [6];
    b[0] = 8'(x0); b[1] = 8'(y0); b[2] = 8'(x1); b[3] = 8'(y1); b[4] = 8'(x2); b[5] = 8'(y2);
    return {b[5], b[4], b[3], b[2], b[1], b[0]};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_bm(input string nm, input logic [4095:0] act, input logic [4095:0] exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      first = -1;
      for (int i = 0; i < 4096; i++) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s bitmap: got popcount %0d, expected popcount %0d, first differing bit %0d",
               nm, $countones(act), $countones(exp), first);
    end
  endtask

  // Drive one start pulse; the pulse is sampled at the next edge (cycle 1 = MINMAX follows).
  task automatic start(input vec_t v);
    @(negedge clk);
    coordinates = v.coords;
    vertice_num = v.vnum;
    raster_en   = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    raster_en = 1'b0;
    cyc = 1;
  endtask

  // Wait for done, pulsing raster_en again at cycle en_at (0 = never), then score.
  task automatic finish_run(input int en_at);
    vec_t e;
    check("busy_after_start", raster_busy, 1);
    while (!raster_done && cyc < 400) begin
      if (cyc == 2) begin
        coordinates = 48'({$urandom(), $urandom()});
        vertice_num = ~vertice_num;
      end
      raster_en = (en_at != 0 && cyc == en_at);
      @(posedge clk); #1;
      cyc++;
    end
    raster_en = 1'b0;
    e = sb_q.pop_front();
    if (!raster_done) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no raster_done within %0d cycles", e.name, cyc);
      return;
    end
    check({e.name, "_latency"}, cyc, e.lat);
    check_bm(e.name, line_buffer, e.bm);
    check({e.name, "_popcount"}, $countones(line_buffer), e.pop);
    @(posedge clk); #1;
    check({e.name, "_done_width"}, raster_done, 0);
    check({e.name, "_idle_busy"}, raster_busy, 0);
    check_bm({e.name, "_hold"}, line_buffer, e.bm);
  endtask

  initial begin
    logic [4095:0] bm;

    bm = '0; for (int i = 0; i <= 5; i++) bm[i] = 1'b1;
    vecs[0] = '{"horizontal", pk(10, 20, 15, 20, 0, 0), 1'b0, 9, 6, bm};
    bm = '0; bm[0] = 1'b1; bm[65] = 1'b1; bm[130] = 1'b1; bm[195] = 1'b1;
    vecs[1] = '{"diagonal", pk(0, 0, 3, 3, 0, 0), 1'b0, 7, 4, bm};
    bm = '0;
    for (int r = 0; r <= 4; r++) begin bm[r] = 1'b1; bm[r*64] = 1'b1; bm[r*64 + 4 - r] = 1'b1; end
    vecs[2] = '{"triangle", pk(5, 5, 9, 5, 5, 9), 1'b1, 20, 12, bm};
    bm = '0; for (int i = 0; i < 64; i++) bm[i] = 1'b1;
    vecs[3] = '{"clip", pk(0, 0, 100, 0, 0, 0), 1'b0, 104, 64, bm};
    bm = '0; bm[0] = 1'b1;
    vecs[4] = '{"point", pk(7, 7, 7, 7, 0, 0), 1'b0, 4, 1, bm};
    bm = '0; bm[2] = 1'b1; bm[66] = 1'b1; bm[129] = 1'b1; bm[193] = 1'b1; bm[256] = 1'b1; bm[320] = 1'b1;
    vecs[5] = '{"steep_neg", pk(2, 0, 0, 5, 0, 0), 1'b0, 9, 6, bm};

    #1 n_rst = 1'b0;
    #3;
    check("reset_busy", raster_busy, 0);
    check("reset_done", raster_done, 0);
    check("reset_popcount", $countones(line_buffer), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", raster_busy, 0);

    for (int i = 0; i < 6; i++) begin
      start(vecs[i]);
      finish_run(0);
    end

    // raster_en during STEP must neither restart nor queue another run.
    start(vecs[3]);
    finish_run(50);
    repeat (5) @(posedge clk);
    #1;
    check("no_queued_restart", raster_busy, 0);
    start(vecs[4]);
    finish_run(3);

    // Asynchronous reset while the triangle is mid-STEP.
    start(vecs[2]);
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("pre_reset_nonzero", (line_buffer != '0), 1);
    #2 n_rst = 1'b0;
    #1;
    check("abort_busy", raster_busy, 0);
    check("abort_done", raster_done, 0);
    check("abort_popcount", $countones(line_buffer), 0);
    sb_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    start(vecs[2]);
    finish_run(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
